// File: rtl/cordic_pkg.sv
// Shared constants for the rotation and vectoring CORDIC blocks.
// Angles are binary: 2^(ANGLE_W-1) LSB = 180 deg, wrapping naturally.
package cordic_pkg;

  localparam int unsigned ANGLE_W    = 24;
  localparam int unsigned K_Q16      = 39797;    // 0.607253 in Q16, inverse CORDIC gain
  localparam int unsigned ANGLE_90   = 4194304;  // 2^22
  localparam int unsigned ANGLE_180  = 8388608;  // 2^23
  localparam int unsigned ATAN_N     = 22;       // enough entries for ITER up to ANGLE_W-2
  localparam int unsigned ATAN_IDX_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRot,
    StDone
  } crd_state_e;

  // round(atan(2^-i) / pi * 2^23)
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [ATAN_N] = '{
    24'd2097152, 24'd1238021, 24'd654136, 24'd332050,
    24'd166669,  24'd83416,   24'd41718,  24'd20860,
    24'd10430,   24'd5215,    24'd2608,   24'd1304,
    24'd652,     24'd326,     24'd163,    24'd81,
    24'd41,      24'd20,      24'd10,     24'd5,
    24'd3,       24'd1
  };

endpackage

// File: rtl/cordic_rotate_if.sv
// Start/done handshake and operand/result bundle for the rotation CORDIC.
interface cordic_rotate_if #(
  parameter int unsigned DATA_W = 24
);

  logic                     crd_start;
  logic signed [DATA_W-1:0] crd_magnitude;
  logic signed [DATA_W-1:0] crd_angle;
  logic                     crd_busy;
  logic                     crd_done;
  logic signed [DATA_W-1:0] crd_x;
  logic signed [DATA_W-1:0] crd_y;

  modport master (
    output crd_start, crd_magnitude, crd_angle,
    input  crd_busy, crd_done, crd_x, crd_y
  );

  modport slave (
    input  crd_start, crd_magnitude, crd_angle,
    output crd_busy, crd_done, crd_x, crd_y
  );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup shared by the CORDIC blocks.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [ATAN_IDX_W-1:0] i_idx,
  output logic [ANGLE_W-1:0]    o_atan
);

  // Indices past the end of the table read as zero.
  always_comb begin
    o_atan = '0;
    if (i_idx < ATAN_IDX_W'(ATAN_N)) begin
      o_atan = ATAN_TABLE[i_idx];
    end
  end

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (magnitude, angle) -> (x, y), one micro-step per clock.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ITER   = 16,
  parameter int unsigned GUARD  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cordic_rotate_if.slave crd
);

  localparam int unsigned DW = DATA_W + GUARD;  // x/y datapath width
  localparam int unsigned PW = DATA_W + 17;     // magnitude * K_Q16 + rounding
  localparam int unsigned IW = ATAN_IDX_W;

  localparam logic [DATA_W-1:0] Ang90   = {2'b01, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] AngM90  = {2'b11, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] Ang180  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SatMax  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IW-1:0]     IterEnd = IW'(ITER - 1);

  crd_state_e r_state, w_state_nx;

  logic        [DATA_W-1:0] r_mag;
  logic signed [DATA_W-1:0] r_ang;
  logic signed [DW-1:0]     r_x, r_y;
  logic signed [DATA_W-1:0] r_z;
  logic        [IW-1:0]     r_iter;
  logic signed [DATA_W-1:0] r_xo, r_yo;

  logic        [PW-1:0]     w_prod;
  logic        [DW-1:0]     w_m;
  logic                     w_fold;
  logic                     w_last;
  logic                     w_d_pos;
  logic signed [DW-1:0]     w_xsh, w_ysh;
  logic signed [DW-1:0]     w_x_nx, w_y_nx;
  logic signed [DATA_W-1:0] w_z_nx;
  logic        [ANGLE_W-1:0] w_rom;
  logic signed [DATA_W-1:0] w_atan;

  // Clamp the widened datapath back to the output width.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] lo;
    logic signed [DW-1:0] hi;
    lo = DW'($signed(SatMin));
    hi = DW'($signed(SatMax));
    if (v > hi) begin
      sat = $signed(SatMax);
    end else if (v < lo) begin
      sat = $signed(SatMin);
    end else begin
      sat = v[DATA_W-1:0];
    end
  endfunction

  cordic_atan_rom u_atan_rom (
    .i_idx  (r_iter),
    .o_atan (w_rom)
  );

  // The table is in ANGLE_W-bit binary angle; rescale when DATA_W differs.
  if (DATA_W >= ANGLE_W) begin : g_atan_up
    assign w_atan = DATA_W'(w_rom) << (DATA_W - ANGLE_W);
  end else begin : g_atan_dn
    assign w_atan = DATA_W'(w_rom >> (ANGLE_W - DATA_W));
  end

  // Gain pre-compensation, quadrant fold and one micro-rotation step.
  always_comb begin
    w_prod  = PW'(r_mag) * PW'(K_Q16) + PW'(32768);
    w_m     = DW'(w_prod >> 16);
    w_fold  = (r_ang > $signed(Ang90)) || (r_ang < $signed(AngM90));
    w_last  = (r_iter == IterEnd);
    w_d_pos = ~r_z[DATA_W-1];
    w_xsh   = r_x >>> r_iter;
    w_ysh   = r_y >>> r_iter;
    if (w_d_pos) begin
      w_x_nx = r_x - w_ysh;
      w_y_nx = r_y + w_xsh;
      w_z_nx = r_z - w_atan;
    end else begin
      w_x_nx = r_x + w_ysh;
      w_y_nx = r_y - w_xsh;
      w_z_nx = r_z + w_atan;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state: start is only honoured in idle.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle:  if (crd.crd_start) w_state_nx = StLoad;
      StLoad:  w_state_nx = StRot;
      StRot:   if (w_last) w_state_nx = StDone;
      StDone:  w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_ang  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_xo   <= '0;
      r_yo   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (crd.crd_start) begin
            r_mag <= crd.crd_magnitude;
            r_ang <= crd.crd_angle;
          end
        end
        StLoad: begin
          // Outside +/-90 deg: start from the opposite half-plane.
          r_x    <= w_fold ? -$signed(w_m) : $signed(w_m);
          r_y    <= '0;
          r_z    <= w_fold ? r_ang + Ang180 : r_ang;
          r_iter <= '0;
        end
        StRot: begin
          r_x    <= w_x_nx;
          r_y    <= w_y_nx;
          r_z    <= w_z_nx;
          r_iter <= r_iter + IW'(1);
          // Results land as DONE is entered so they are valid with the pulse.
          if (w_last) begin
            r_xo <= sat(w_x_nx);
            r_yo <= sat(w_y_nx);
          end
        end
        default: ;
      endcase
    end
  end

  // Status decoded straight from state.
  assign crd.crd_busy = (r_state != StIdle);
  assign crd.crd_done = (r_state == StDone);
  assign crd.crd_x    = r_xo;
  assign crd.crd_y    = r_yo;

endmodule
